// File: rtl/onehot_rr_arbiter_pkg.sv
// onehot_rr_arbiter_pkg: shared widths, FSM states and helpers for the round-robin one-hot arbiter.
package onehot_arb_pkg;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;
   typedef enum logic {IDLE, OFFER} state_t;
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction
endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// onehot_rr_arbiter_if: request/grant bus between the arbiter (master) and its requesters/encoder (slave).
// The lock signal exists only when ONEHOT_ARB_LOCK_EN is defined.
interface onehot_rr_arbiter_if;
   import onehot_arb_pkg::*;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic             gnt_ready;
   logic [IDX_W-1:0] gnt_idx;
   logic             timeout;
`ifdef ONEHOT_ARB_LOCK_EN
   logic             lock;
   modport master (input req, gnt_ready, lock, output gnt, gnt_valid, gnt_idx, timeout);
   modport slave  (output req, gnt_ready, lock, input gnt, gnt_valid, gnt_idx, timeout);
`else
   modport master (input req, gnt_ready, output gnt, gnt_valid, gnt_idx, timeout);
   modport slave  (output req, gnt_ready, input gnt, gnt_valid, gnt_idx, timeout);
`endif
endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr and descending with wrap.
module rr_pick
   import onehot_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] win_idx
);
   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] pos;
   // rot[7] is req[ptr], rot[6] is req[ptr-1], ... so the highest set bit wins
   always_comb begin
      rot = N_REQ'({req, req} >> ({1'b0, ptr} + 4'd1));
      pos = '0;
      for (int i = 0; i < N_REQ; i++) if (rot[i]) pos = IDX_W'(i);
      any = |req;
      win_idx = ptr + IDX_W'(1) + pos;
   end
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter presenting a registered one-hot grant over valid/ready.
// Define ONEHOT_ARB_LOCK_EN to add a lock input that keeps the pointer on the winner at transfer.
module onehot_rr_arbiter
   import onehot_arb_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input logic clk,
   input logic rst_n,
   onehot_rr_arbiter_if.master bus
);
   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx, win, idx_nx;
   logic [N_REQ-1:0] gnt_nx;
   logic [CW-1:0]    wait_cnt, wait_nx;
   logic             any, valid_nx, to_nx, lk, expire;
   rr_pick u_pick (.req(bus.req), .ptr(ptr), .any(any), .win_idx(win));
`ifdef ONEHOT_ARB_LOCK_EN
   assign lk = bus.lock;
`else
   assign lk = 1'b0;
`endif
   // the stall that would bring wait_cnt to MAX_WAIT aborts the offer
   assign expire = (MAX_WAIT > 0) && (int'(wait_cnt) + 1 >= MAX_WAIT);
   always_comb begin
      state_nx = state;
      ptr_nx = ptr;
      wait_nx = wait_cnt;
      gnt_nx = '0;
      valid_nx = 1'b0;
      idx_nx = '0;
      to_nx = 1'b0;
      if (state == IDLE) begin
         if (any) begin
            state_nx = OFFER;
            gnt_nx = idx_to_onehot(win);
            valid_nx = 1'b1;
            idx_nx = win;
            wait_nx = '0;
         end
      end else if (bus.gnt_ready) begin
         state_nx = IDLE;
         ptr_nx = lk ? bus.gnt_idx : bus.gnt_idx - IDX_W'(1);
      end else if (expire) begin
         state_nx = IDLE;
         ptr_nx = bus.gnt_idx - IDX_W'(1);
         to_nx = 1'b1;
      end else begin
         gnt_nx = bus.gnt;
         valid_nx = 1'b1;
         idx_nx = bus.gnt_idx;
         wait_nx = (int'(wait_cnt) < MAX_WAIT) ? wait_cnt + 1'b1 : wait_cnt;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '1;
         wait_cnt <= '0;
         bus.gnt <= '0;
         bus.gnt_valid <= 1'b0;
         bus.gnt_idx <= '0;
         bus.timeout <= 1'b0;
      end else begin
         state <= state_nx;
         ptr <= ptr_nx;
         wait_cnt <= wait_nx;
         bus.gnt <= gnt_nx;
         bus.gnt_valid <= valid_nx;
         bus.gnt_idx <= idx_nx;
         bus.timeout <= to_nx;
      end
   end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: scoreboard bench; a behavioural model queues the expected outputs of every cycle.
module tb_onehot_rr_arbiter;
   localparam int MW = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   logic [12:0] exp_q[$];
   int  m_ptr, m_win, m_wait;
   bit  m_busy, m_to;
   onehot_rr_arbiter_if bus();
   onehot_rr_arbiter #(.MAX_WAIT(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got gnt/v/idx/to=%h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] observed();
      return {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout};
   endfunction

   task automatic model(input logic [7:0] r, input logic rdy, input logic lk);
      bit found = 0;
      m_to = 0;
      if (!m_busy) begin
         for (int k = 0; k < 8; k++) begin
            int c = (m_ptr - k + 8) % 8;
            if (!found && r[c]) begin
               found = 1;
               m_win = c;
            end
         end
         if (found) begin
            m_busy = 1;
            m_wait = 0;
         end
      end else if (rdy) begin
         m_busy = 0;
         m_ptr = lk ? m_win : (m_win + 7) % 8;
      end else if (m_wait + 1 >= MW) begin
         m_busy = 0;
         m_ptr = (m_win + 7) % 8;
         m_to = 1;
      end else m_wait++;
      exp_q.push_back({m_busy ? 8'(1 << m_win) : 8'h00, m_busy, m_busy ? 3'(m_win) : 3'd0, m_to});
   endtask

   task automatic step(input string tag, input logic [7:0] r, input logic rdy, input logic lk);
      logic lke = 1'b0;
      bus.req = r;
      bus.gnt_ready = rdy;
`ifdef ONEHOT_ARB_LOCK_EN
      bus.lock = lk;
      lke = lk;
`endif
      model(r, rdy, lke);
      @(posedge clk);
      #1;
      check(tag, observed(), exp_q.pop_front());
      check({tag, "_inv"}, {12'd0, $onehot0(bus.gnt) && ((bus.gnt != 0) == bus.gnt_valid)}, 13'd1);
   endtask

   task automatic reset_pulse();
      #3 rst_n = 1'b0;
      #1 check("async_rst", observed(), 13'd0);
      m_busy = 0;
      m_to = 0;
      m_ptr = 7;
      m_wait = 0;
      exp_q.delete();
      @(posedge clk);
      #1 check("rst_hold", observed(), 13'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bus.req = '0;
      bus.gnt_ready = 1'b0;
`ifdef ONEHOT_ARB_LOCK_EN
      bus.lock = 1'b0;
`endif
      @(posedge clk);
      #1 reset_pulse();
      step("idle", 8'h00, 1'b1, 1'b0);
      step("single", 8'h04, 1'b1, 1'b0);
      step("single_bubble", 8'h00, 1'b1, 1'b0);
      step("single_ptr", 8'h06, 1'b1, 1'b0);
      step("single_done", 8'h00, 1'b1, 1'b0);
      reset_pulse();
      for (int i = 0; i < 18; i++) step("fair", 8'hFF, 1'b1, 1'b0);
      reset_pulse();
      step("stall_grant", 8'h81, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("stall_hold", 8'h01, 1'b0, 1'b0);
      step("stall_xfer", 8'h01, 1'b1, 1'b0);
      step("stall_bubble", 8'h01, 1'b1, 1'b0);
      step("stall_next", 8'h01, 1'b1, 1'b0);
      reset_pulse();
      for (int i = 0; i < 21; i++) step("timeout", 8'h10, 1'b0, 1'b0);
      reset_pulse();
      for (int i = 0; i < 16; i++) step("limit_stall", 8'h10, 1'b0, 1'b0);
      step("limit_xfer", 8'h10, 1'b1, 1'b0);
      step("limit_bubble", 8'h00, 1'b1, 1'b0);
      reset_pulse();
      for (int i = 0; i < 3; i++) step("mid_offer", 8'h08, 1'b0, 1'b0);
      reset_pulse();
      for (int i = 0; i < 4; i++) step("post_rst", 8'h08, 1'b1, 1'b0);
`ifdef ONEHOT_ARB_LOCK_EN
      reset_pulse();
      for (int i = 0; i < 6; i++) step("lock", 8'h22, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step("unlock", 8'h22, 1'b1, 1'b0);
`endif
      reset_pulse();
      for (int i = 0; i < 300; i++)
         step("random", 8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
